graph: RTL and testbench
========================

GRAPH -- requirements
Module: graph

Interface
REQ-001 Parameter X_STEP, default 10: x increment between consecutive points (signed 32-bit).
REQ-002 Parameter AMP, default 100: sine amplitude in output LSBs (1..32767).
REQ-003 Parameter Y_OFFSET, default 0: constant added to every y value.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 xs  output  32 x [63:0] unpacked  x coordinate of point i, signed two's complement.
REQ-007 ys  output  32 x [63:0] unpacked  y coordinate of point i, signed two's complement.
REQ-008 complete  output  1  high once all 64 points are valid.

Function
REQ-009 Point i (0..63) SHALL be xs[i] = i*X_STEP and ys[i] = Y_OFFSET + round(AMP*sin(2*pi*i/64)), within +/-1 LSB of the exact value for ys.
REQ-010 Points SHALL be computed strictly in order i = 0..63, one at a time, by an iterative CORDIC in rotation mode.
REQ-011 Quadrant reduction: q = i[5:4], r = i[3:0], residual angle a = r*2*pi/64; sin(theta) = sin(a), cos(a), -sin(a), -cos(a) for q = 0, 1, 2, 3.
REQ-012 CORDIC datapath: Q16.16 x/y, Q2.30 angle; x0 = round(AMP*0.6072529*2^16), y0 = 0, z0 = a; exactly 12 iterations; result rounded as (v + 2^15) >>> 16.
REQ-013 Per-point schedule SHALL be 14 cycles: 1 LOAD, 12 ITER, 1 WRITE; xs[i]/ys[i] update only in that point's WRITE cycle.
REQ-014 FSM states: IDLE -> LOAD -> ITER (x12) -> WRITE -> LOAD (i<63) or DONE (i=63); DONE holds until reset.
REQ-015 IDLE SHALL last exactly one cycle after reset release, so the first LOAD is the 2nd rising edge with rst low.
REQ-016 complete SHALL go high in the cycle after the WRITE of point 63 (897 cycles after the first rising edge with rst low) and stay high.
REQ-017 Entries not yet written SHALL read 0; written entries SHALL hold their value until reset.
REQ-018 The x product SHALL wrap modulo 2^32; the y sum SHALL saturate to the signed 32-bit range.

Reset
REQ-019 While rst=1, all xs, ys and complete SHALL be 0 and the FSM in IDLE, immediately and independent of clk.
REQ-020 Reset asserted mid-computation SHALL discard the partial result; computation SHALL restart from i=0 after release.
REQ-021 An X rst before the first assertion need not be handled; behaviour is defined from the first rst=1 onward.

Structure
REQ-022 Package graph_pkg SHALL hold N_POINTS=64, CORDIC_ITERS=12, the Q2.30 atan table (12 entries), the x0 gain constant and the FSM state enum.
REQ-023 One sub-module, graph_cordic (start/busy/done handshake, angle in, sin/cos out), SHALL contain the iteration; graph holds the FSM, index counter, quadrant mapping and output registers.

Verification
REQ-024 Default params, rst high 3 cycles then low -> complete rises exactly 897 cycles after the first rising edge with rst low; xs[5]=50, xs[63]=630.
REQ-025 After complete -> ys[0]=0, ys[16]=100, ys[32]=0, ys[48]=-100, ys[8]=71, ys[56]=-71 (each +/-1).
REQ-026 Sample at cycle 200 -> points 0..13 written, points 14..63 read 0, complete=0.
REQ-027 Assert rst at cycle 300 for 2 cycles -> all outputs 0 at once; after release, identical final values and same 897-cycle latency.
REQ-028 AMP=1000, Y_OFFSET=-5, X_STEP=-3 -> ys[16]=995, ys[48]=-1005, xs[10]=-30 (ys +/-1).

Source files
------------

// File: rtl/graph_pkg.sv
// Shared constants, CORDIC tables and FSM encoding for the sine graph generator.
package graph_pkg;

    localparam int N_POINTS     = 64;
    localparam int IDX_W        = 6;
    localparam int CORDIC_ITERS = 12;
    localparam int ITER_W       = 4;
    localparam int XW           = 40;
    localparam int ZW           = 34;

    // CORDIC gain 0.6072529 scaled by 1e7, and pi/32 in Q2.30
    localparam longint K_GAIN_E7 = 64'sd6072529;
    localparam int     STEP_Q30  = 105414357;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic int atan_q30(input logic [ITER_W-1:0] k);
        int v;
        v = 0;
        case (k)
            4'd0:    v = 843314857;
            4'd1:    v = 497837829;
            4'd2:    v = 263043837;
            4'd3:    v = 133525159;
            4'd4:    v = 67021687;
            4'd5:    v = 33543516;
            4'd6:    v = 16775851;
            4'd7:    v = 8388437;
            4'd8:    v = 4194283;
            4'd9:    v = 2097149;
            4'd10:   v = 1048576;
            4'd11:   v = 524288;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic longint x0_q16(input int amp);
        return (longint'(amp) * 64'sd65536 * K_GAIN_E7 + 64'sd5000000)
               / 64'sd10000000;
    endfunction

endpackage

// File: rtl/graph_cordic.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle after start.
module graph_cordic
    import graph_pkg::*;
#(
    parameter int AMP = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] angle,
    output logic               busy,
    output logic               done,
    output logic signed [31:0] sin_out,
    output logic signed [31:0] cos_out
);

    localparam logic signed [XW-1:0] X0    = XW'(x0_q16(AMP));
    localparam logic signed [XW-1:0] ROUND = XW'(32768);

    logic signed [XW-1:0] x, y, x_n, y_n, x_sh, y_sh;
    logic signed [ZW-1:0] z, z_n, at;
    logic [ITER_W-1:0]    k;

    always_comb begin
        x_sh = x >>> k;
        y_sh = y >>> k;
        at   = ZW'(atan_q30(k));
        if (z[ZW-1]) begin
            x_n = x + y_sh;
            y_n = y - x_sh;
            z_n = z + at;
        end else begin
            x_n = x - y_sh;
            y_n = y + x_sh;
            z_n = z - at;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            k    <= '0;
            busy <= 1'b0;
        end else if (start) begin
            x    <= X0;
            y    <= '0;
            z    <= ZW'(angle);
            k    <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            x <= x_n;
            y <= y_n;
            z <= z_n;
            k <= k + 1'b1;
            if (k == ITER_W'(CORDIC_ITERS - 1))
                busy <= 1'b0;
        end
    end

    // done marks the final rotation; results are stable from the next cycle
    assign done    = busy && (k == ITER_W'(CORDIC_ITERS - 1));
    assign sin_out = 32'((y + ROUND) >>> 16);
    assign cos_out = 32'((x + ROUND) >>> 16);

endmodule

// File: rtl/graph.sv
// Generates 64 points of one sine period, one CORDIC evaluation per point.
module graph
    import graph_pkg::*;
#(
    parameter int X_STEP   = 10,
    parameter int AMP      = 100,
    parameter int Y_OFFSET = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic signed [31:0] xs [N_POINTS],
    output logic signed [31:0] ys [N_POINTS],
    output logic               complete
);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx;
    logic               start, cord_busy, cord_done;
    logic signed [31:0] angle, sin_v, cos_v, q_val, x_val, y_val;
    longint             y_sum;

    graph_cordic #(.AMP(AMP)) u_cordic (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .angle   (angle),
        .busy    (cord_busy),
        .done    (cord_done),
        .sin_out (sin_v),
        .cos_out (cos_v)
    );

    always_comb begin
        state_n = state;
        start   = 1'b0;
        unique case (state)
            S_IDLE: state_n = S_LOAD;
            S_LOAD: begin
                start   = 1'b1;
                state_n = S_ITER;
            end
            S_ITER: begin
                if (cord_done || !cord_busy)
                    state_n = S_WRITE;
            end
            S_WRITE: begin
                if (idx == IDX_W'(N_POINTS - 1))
                    state_n = S_DONE;
                else
                    state_n = S_LOAD;
            end
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Residual angle within the quadrant, then map back by symmetry
    always_comb begin
        angle = 32'(int'(idx[3:0]) * STEP_Q30);
        q_val = sin_v;
        unique case (idx[5:4])
            2'd0: q_val = sin_v;
            2'd1: q_val = cos_v;
            2'd2: q_val = -sin_v;
            2'd3: q_val = -cos_v;
            default: q_val = sin_v;
        endcase
        x_val = int'(idx) * X_STEP;
        y_sum = longint'(Y_OFFSET) + longint'(q_val);
        if (y_sum > 64'sd2147483647)
            y_val = 32'sh7FFFFFFF;
        else if (y_sum < -64'sd2147483648)
            y_val = 32'sh80000000;
        else
            y_val = 32'(y_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            complete <= 1'b0;
            for (int i = 0; i < N_POINTS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (state == S_WRITE) begin
                xs[idx] <= x_val;
                ys[idx] <= y_val;
                if (idx == IDX_W'(N_POINTS - 1))
                    complete <= 1'b1;
                else
                    idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_graph.sv
// Directed bench: latency, partial progress, async reset and point values.
module tb_graph;
    import graph_pkg::*;

    logic               clk;
    logic               rst;
    logic signed [31:0] xs [N_POINTS];
    logic signed [31:0] ys [N_POINTS];
    logic               complete;
    logic signed [31:0] xs2 [N_POINTS];
    logic signed [31:0] ys2 [N_POINTS];
    logic               complete2;

    int errors = 0;
    int checks = 0;
    int n;

    graph dut (
        .clk      (clk),
        .rst      (rst),
        .xs       (xs),
        .ys       (ys),
        .complete (complete)
    );

    graph #(.X_STEP(-3), .AMP(1000), .Y_OFFSET(-5)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .xs       (xs2),
        .ys       (ys2),
        .complete (complete2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        checks++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d +/-1", tag, obs, exp);
        end
    endtask

    // Counts rising edges since release until complete, bounded
    task automatic wait_complete(input int from, output int cnt);
        cnt = from;
        while (complete !== 1'b1 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic check_final(input string run);
        check_eq({run, " xs5"}, xs[5], 50);
        check_eq({run, " xs63"}, xs[63], 630);
        check_near({run, " ys0"}, ys[0], 0);
        check_near({run, " ys4"}, ys[4], 38);
        check_near({run, " ys8"}, ys[8], 71);
        check_near({run, " ys12"}, ys[12], 92);
        check_near({run, " ys16"}, ys[16], 100);
        check_near({run, " ys24"}, ys[24], 71);
        check_near({run, " ys32"}, ys[32], 0);
        check_near({run, " ys40"}, ys[40], -71);
        check_near({run, " ys48"}, ys[48], -100);
        check_near({run, " ys56"}, ys[56], -71);
        check_near({run, " ys60"}, ys[60], -38);
        check_eq({run, " complete2"}, int'(complete2), 1);
        check_near({run, " p2 ys16"}, ys2[16], 995);
        check_near({run, " p2 ys48"}, ys2[48], -1005);
        check_near({run, " p2 ys0"}, ys2[0], -5);
        check_near({run, " p2 ys8"}, ys2[8], 702);
        check_eq({run, " p2 xs10"}, xs2[10], -30);
        check_eq({run, " p2 xs63"}, xs2[63], -189);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset xs5", xs[5], 0);
        check_eq("reset ys16", ys[16], 0);
        check_eq("reset complete", int'(complete), 0);
        check_eq("reset p2 xs10", xs2[10], 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (200) @(posedge clk);
        #1;
        check_eq("c200 xs13", xs[13], 130);
        check_near("c200 ys13", ys[13], 96);
        check_near("c200 ys8", ys[8], 71);
        check_eq("c200 xs14", xs[14], 0);
        check_eq("c200 ys14", ys[14], 0);
        check_eq("c200 xs63", xs[63], 0);
        check_eq("c200 complete", int'(complete), 0);
        check_eq("c200 p2 xs14", xs2[14], 0);

        wait_complete(200, n);
        check_eq("latency run1", n, 897);
        check_final("run1");

        @(posedge clk);
        #1;
        check_eq("complete held", int'(complete), 1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async xs5", xs[5], 0);
        check_eq("async ys16", ys[16], 0);
        check_eq("async xs13", xs[13], 0);
        check_eq("async complete", int'(complete), 0);
        check_eq("async p2 ys16", ys2[16], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait_complete(0, n);
        check_eq("latency run2", n, 897);
        check_final("run2");
        for (int i = 0; i < N_POINTS; i++)
            check_eq($sformatf("run2 xs%0d", i), xs[i], i * 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
